// File: rtl/fetch_unit.sv
// Instruction fetch: PC, in-order imem requests, {word,pc} FIFO feeding decode; head valid 1 cycle after response.
// Backpressure: stall holds the head; issue stops once outstanding + buffered (less a same-cycle pop) reaches DEPTH.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  op,
  output logic [2:0]  f3,
  output logic        f7
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] r_pc;
  logic [31:0] r_fifo_word [DEPTH];
  logic [31:0] r_fifo_pc   [DEPTH];
  logic [31:0] r_inf_pc    [DEPTH];
  ptr_t        r_rd_ptr, r_wr_ptr, r_inf_rd, r_inf_wr;
  cnt_t        r_count, r_outst, r_drop;

  logic        w_resp, w_accept, w_pop, w_push;
  logic [CW:0] w_used;
  logic [31:0] w_target;

  assign w_target    = redirect_target & ~32'h3;
  assign instr_valid = (r_count != '0);
  assign w_resp      = imem_rvalid & (r_outst != '0);
  assign w_pop       = instr_valid & ~stall & ~redirect;
  assign w_push      = w_resp & (r_drop == '0) & ~redirect;
  // A same-cycle pop frees its slot, which keeps a 1-cycle memory streaming at full rate.
  assign w_used      = {1'b0, r_outst} + {1'b0, r_count} - (CW+1)'(w_pop);
  assign imem_req    = rst_n & ~redirect & (w_used < DEPTH_C);
  assign imem_addr   = r_pc;
  assign w_accept    = imem_req & imem_ready;

  assign instr    = instr_valid ? r_fifo_word[r_rd_ptr] : NOP;
  assign instr_pc = instr_valid ? r_fifo_pc[r_rd_ptr] : 32'h0;
  assign op       = instr[6:0];
  assign f3       = instr[14:12];
  assign f7       = instr[30];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_word[r_wr_ptr] <= imem_rdata;
      r_fifo_pc[r_wr_ptr]   <= r_inf_pc[r_inf_rd];
    end
    if (w_accept) r_inf_pc[r_inf_wr] <= r_pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= RESET_PC;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_inf_rd <= '0;
      r_inf_wr <= '0;
      r_count  <= '0;
      r_outst  <= '0;
      r_drop   <= '0;
    end else begin
      if (redirect)      r_pc <= w_target;
      else if (w_accept) r_pc <= r_pc + 32'd4;
      r_outst <= r_outst + cnt_t'(w_accept) - cnt_t'(w_resp);
      if (w_accept) r_inf_wr <= r_inf_wr + ptr_t'(1);
      if (w_resp)   r_inf_rd <= r_inf_rd + ptr_t'(1);
      if (redirect) begin
        // Every response still owed, minus one landing now, belongs to the old path.
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_drop   <= r_outst - cnt_t'(w_resp);
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + ptr_t'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + ptr_t'(1);
        r_count <= r_count + cnt_t'(w_push) - cnt_t'(w_pop);
        if (w_resp && (r_drop != '0)) r_drop <= r_drop - cnt_t'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: queue-based imem model with programmable latency, word = address.
module tb_fetch_unit;
  logic        clk, rst_n;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect, stall;
  logic [31:0] redirect_target;
  logic        instr_valid, f7;
  logic [31:0] instr, instr_pc;
  logic [6:0]  op;
  logic [2:0]  f3;

  logic        wr_req, wr_ready, wr_rvalid, wr_redirect, wr_stall, wr_valid, wr_f7;
  logic [31:0] wr_addr, wr_rdata, wr_target, wr_instr, wr_pc;
  logic [6:0]  wr_op;
  logic [2:0]  wr_f3;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int lat = 1;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_target(redirect_target), .stall(stall),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .op(op), .f3(f3), .f7(f7)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_req(wr_req), .imem_addr(wr_addr),
    .imem_ready(wr_ready), .imem_rvalid(wr_rvalid), .imem_rdata(wr_rdata),
    .redirect(wr_redirect), .redirect_target(wr_target), .stall(wr_stall),
    .instr_valid(wr_valid), .instr(wr_instr), .instr_pc(wr_pc),
    .op(wr_op), .f3(wr_f3), .f7(wr_f7)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle echo memory for the wrap instance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_rvalid <= 1'b0;
      wr_rdata  <= 32'h0;
    end else begin
      wr_rvalid <= wr_req & wr_ready;
      wr_rdata  <= wr_addr;
    end
  end

  // Main memory model: in-order, response presented lat cycles after acceptance.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        mq_addr.delete(); mq_due.delete();
        imem_rvalid = 1'b0;
      end else if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mq_addr[0];
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      @(negedge clk);
      if (rst_n && imem_req && imem_ready) begin
        mq_addr.push_back(imem_addr);
        mq_due.push_back(cyc + lat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    redirect = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%h exp=0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%h exp=0", instr_valid); end
    total++; if (instr !== 32'h13) begin bad++; $display("FAIL rst_instr got=%h exp=00000013", instr); end
    total++; if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", instr_pc); end
    total++; if ({op, f3, f7} !== {7'h13, 3'h0, 1'b0}) begin bad++; $display("FAIL rst_dec got=%h/%h/%h exp=13/0/0", op, f3, f7); end
  endtask

  task automatic test_straight();
    lat = 1; stall = 1'b0;
    do_reset();
    @(negedge clk);
    total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h0, 1'b0}) begin bad++; $display("FAIL st_c0 got=%h/%h/%h exp=1/0/0", imem_req, imem_addr, instr_valid); end
    next_cycle(); @(negedge clk);
    total++; if ({imem_req, imem_addr, instr_valid} !== {1'b1, 32'h4, 1'b0}) begin bad++; $display("FAIL st_c1 got=%h/%h/%h exp=1/4/0", imem_req, imem_addr, instr_valid); end
    next_cycle(); @(negedge clk);
    total++; if ({instr_valid, instr_pc, instr, imem_req, imem_addr} !== {1'b1, 32'h0, 32'h0, 1'b1, 32'h8}) begin bad++; $display("FAIL st_c2 got=%h/%h/%h/%h/%h exp=1/0/0/1/8", instr_valid, instr_pc, instr, imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    total++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4, 32'h4}) begin bad++; $display("FAIL st_c3 got=%h/%h/%h exp=1/4/4", instr_valid, instr_pc, instr); end
  endtask

  task automatic test_stall();
    int exp_pc, pops;
    for (int i = 0; i < 5; i++) begin
      next_cycle(); stall = 1'b1; @(negedge clk);
      total++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h8, 32'h8}) begin bad++; $display("FAIL stall_hold%0d got=%h/%h/%h exp=1/8/8", i, instr_valid, instr_pc, instr); end
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req%0d got=%h exp=0", i, imem_req); end
    end
    exp_pc = 8; pops = 0;
    for (int i = 0; i < 6; i++) begin
      next_cycle(); stall = 1'b0; @(negedge clk);
      if (instr_valid) begin
        total++; if (instr_pc !== 32'(exp_pc)) begin bad++; $display("FAIL stall_seq got=%h exp=%h", instr_pc, exp_pc); end
        exp_pc += 4; pops++;
      end
    end
    total++; if (pops != 6) begin bad++; $display("FAIL stall_pops got=%0d exp=6", pops); end
  endtask

  task automatic test_redirect_fast();
    next_cycle(); redirect = 1'b1; redirect_target = 32'h4000_7069; @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rf_req_n got=%h exp=0", imem_req); end
    next_cycle(); redirect = 1'b0; @(negedge clk);
    total++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h4000_7068}) begin bad++; $display("FAIL rf_n1 got=%h/%h/%h exp=0/1/40007068", instr_valid, imem_req, imem_addr); end
    next_cycle(); @(negedge clk);
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL rf_n2 got=%h exp=0", instr_valid); end
    next_cycle(); @(negedge clk);
    total++; if ({instr_valid, instr_pc, instr} !== {1'b1, 32'h4000_7068, 32'h4000_7068}) begin bad++; $display("FAIL rf_n3 got=%h/%h/%h exp=1/40007068/40007068", instr_valid, instr_pc, instr); end
    total++; if ({op, f3, f7} !== {7'h68, 3'h7, 1'b1}) begin bad++; $display("FAIL rf_dec got=%h/%h/%h exp=68/7/1", op, f3, f7); end
  endtask

  task automatic test_redirect_inflight();
    logic [31:0] first_addr, vpc, vinstr;
    bit have_addr, found;
    lat = 3; stall = 1'b0;
    do_reset();
    @(negedge clk);
    next_cycle(); @(negedge clk);
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin bad++; $display("FAIL ri_c1 got=%h/%h exp=1/4", imem_req, imem_addr); end
    next_cycle(); redirect = 1'b1; redirect_target = 32'h0000_0103; @(negedge clk);
    next_cycle(); redirect = 1'b0; @(negedge clk);
    total++; if ({imem_req, instr_valid} !== 2'b00) begin bad++; $display("FAIL ri_c3 got=%h/%h exp=0/0", imem_req, instr_valid); end
    have_addr = 0; found = 0; first_addr = 0; vpc = 0; vinstr = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      next_cycle(); @(negedge clk);
      if (imem_req && !have_addr) begin have_addr = 1; first_addr = imem_addr; end
      if (instr_valid) begin found = 1; vpc = instr_pc; vinstr = instr; end
    end
    total++; if (!found) begin bad++; $display("FAIL ri_timeout got=none exp=valid"); end
    total++; if (first_addr !== 32'h100) begin bad++; $display("FAIL ri_addr got=%h exp=00000100", first_addr); end
    total++; if ({vpc, vinstr} !== {32'h100, 32'h100}) begin bad++; $display("FAIL ri_first got=%h/%h exp=100/100", vpc, vinstr); end
  endtask

  task automatic test_redirect_rvalid_stall();
    bit hit, found;
    lat = 3;
    do_reset();
    stall = 1'b1;
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      @(posedge clk); #2;
      if (imem_rvalid && instr_valid) begin hit = 1; redirect = 1'b1; redirect_target = 32'h0000_0202; end
    end
    total++; if (!hit) begin bad++; $display("FAIL rs_coincide got=none exp=rvalid&valid"); end
    @(negedge clk);
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rs_req_n got=%h exp=0", imem_req); end
    next_cycle(); redirect = 1'b0; @(negedge clk);
    total++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h200}) begin bad++; $display("FAIL rs_n1 got=%h/%h/%h exp=0/1/200", instr_valid, imem_req, imem_addr); end
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      next_cycle(); @(negedge clk);
      if (instr_valid) found = 1;
    end
    total++; if ({found, instr_pc, instr} !== {1'b1, 32'h200, 32'h200}) begin bad++; $display("FAIL rs_target got=%h/%h/%h exp=1/200/200", found, instr_pc, instr); end
    next_cycle(); @(negedge clk);
    total++; if ({instr_valid, instr_pc} !== {1'b1, 32'h200}) begin bad++; $display("FAIL rs_hold got=%h/%h exp=1/200", instr_valid, instr_pc); end
    stall = 1'b0;
  endtask

  task automatic test_pc_wrap();
    logic [31:0] seen[$];
    lat = 1;
    do_reset();
    @(negedge clk);
    if (wr_req) seen.push_back(wr_addr);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); @(negedge clk);
      if (wr_req) seen.push_back(wr_addr);
    end
    total++; if (seen.size() < 3) begin bad++; $display("FAIL wrap_count got=%0d exp=>=3", seen.size()); end
    else begin
      total++; if (seen[0] !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_a0 got=%h exp=FFFFFFF8", seen[0]); end
      total++; if (seen[1] !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_a1 got=%h exp=FFFFFFFC", seen[1]); end
      total++; if (seen[2] !== 32'h0) begin bad++; $display("FAIL wrap_a2 got=%h exp=00000000", seen[2]); end
    end
    next_cycle(); @(negedge clk);
    total++; if ({wr_valid, wr_pc, wr_instr} !== {1'b1, 32'h0, 32'h0}) begin bad++; $display("FAIL wrap_pc got=%h/%h/%h exp=1/0/0", wr_valid, wr_pc, wr_instr); end
  endtask

  task automatic test_async_reset();
    lat = 1; stall = 1'b0;
    do_reset();
    repeat (5) next_cycle();
    @(posedge clk); #3;
    total++; if (instr_valid !== 1'b1) begin bad++; $display("FAIL ar_pre got=%h exp=1", instr_valid); end
    rst_n = 1'b0;
    #1;
    total++; if ({instr_valid, imem_req, instr} !== {1'b0, 1'b0, 32'h13}) begin bad++; $display("FAIL ar_now got=%h/%h/%h exp=0/0/13", instr_valid, imem_req, instr); end
    @(posedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    total++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin bad++; $display("FAIL ar_restart got=%h/%h exp=1/0", imem_req, imem_addr); end
    repeat (2) next_cycle();
    @(negedge clk);
    total++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin bad++; $display("FAIL ar_first got=%h/%h exp=1/0", instr_valid, instr_pc); end
  endtask

  initial begin
    rst_n = 1'b1;
    imem_ready = 1'b1; redirect = 1'b0; redirect_target = 32'h0; stall = 1'b0;
    wr_ready = 1'b1; wr_redirect = 1'b0; wr_target = 32'h0; wr_stall = 1'b0;
    #1 rst_n = 1'b0;
    test_reset();
    test_straight();
    test_stall();
    test_redirect_fast();
    test_redirect_inflight();
    test_redirect_rvalid_stall();
    test_pc_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
